// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-end program-counter sequencer.
// Holds the default widths and vectors, the FSM state type and the alignment helper.
package pc_sequencer_pkg;

    localparam int          PCSEQ_WORD_SIZE    = 32;
    localparam logic [31:0] PCSEQ_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] PCSEQ_TRAP_VECTOR  = 32'h0000_0100;

    typedef enum logic [1:0] {
        BOOT      = 2'd0,
        RUN       = 2'd1,
        TRAP_WAIT = 2'd2
    } pcseq_state_t;

    // Instruction fetches must be word aligned; only the two low bits matter.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/pc_sequencer_next_pc_mux.sv
// Combinational next-PC select: fixed priority jalr > jal > br > pc+4,
// plus a misalignment flag that is only raised for redirect targets.
module next_pc_mux
    import pc_sequencer_pkg::*;
#(
    parameter int WORD_SIZE = PCSEQ_WORD_SIZE
) (
    input  logic [WORD_SIZE-1:0] pc,
    input  logic                 jalr_taken,
    input  logic [WORD_SIZE-1:0] jalr_target,
    input  logic                 jal_taken,
    input  logic [WORD_SIZE-1:0] jal_target,
    input  logic                 br_taken,
    input  logic [WORD_SIZE-1:0] br_target,
    output logic [WORD_SIZE-1:0] next_pc,
    output logic                 redirect,
    output logic                 misaligned
);

    localparam logic [WORD_SIZE-1:0] PC_STEP = WORD_SIZE'(4);

    always_comb begin
        next_pc  = pc + PC_STEP;
        redirect = 1'b1;
        if (jalr_taken) begin
            next_pc = jalr_target;
        end else if (jal_taken) begin
            next_pc = jal_target;
        end else if (br_taken) begin
            next_pc = br_target;
        end else begin
            redirect = 1'b0;
        end
    end

    // The sequential path stays 4-aligned by construction, so it never traps.
    assign misaligned = redirect && is_misaligned(next_pc[1:0]);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter register and boot/run/trap FSM at the fetch end of the core.
// Walks pc+4, takes redirects from the jump/branch adders and traps on misaligned targets.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int                   WORD_SIZE    = PCSEQ_WORD_SIZE,
    parameter logic [WORD_SIZE-1:0] RESET_VECTOR = WORD_SIZE'(PCSEQ_RESET_VECTOR),
    parameter logic [WORD_SIZE-1:0] TRAP_VECTOR  = WORD_SIZE'(PCSEQ_TRAP_VECTOR)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 jalr_taken,
    input  logic [WORD_SIZE-1:0] jalr_target,
    input  logic                 jal_taken,
    input  logic [WORD_SIZE-1:0] jal_target,
    input  logic                 br_taken,
    input  logic [WORD_SIZE-1:0] br_target,
    input  logic                 trap_ack,
    output logic [WORD_SIZE-1:0] pc,
    output logic                 pc_valid,
    output logic [WORD_SIZE-1:0] link_addr,
    output logic                 trap,
    output logic [WORD_SIZE-1:0] trap_pc,
    output logic [15:0]          redirect_cnt,
    output pcseq_state_t         dbg_state
);

    localparam logic [1:0] ST_BOOT      = BOOT;
    localparam logic [1:0] ST_RUN       = RUN;
    localparam logic [1:0] ST_TRAP_WAIT = TRAP_WAIT;

    localparam logic [WORD_SIZE-1:0] PC_STEP = WORD_SIZE'(4);
    localparam logic [15:0]          CNT_MAX = 16'hFFFF;

    logic [1:0]           state;
    logic [WORD_SIZE-1:0] next_pc;
    logic                 redirect;
    logic                 misaligned;

    next_pc_mux #(
        .WORD_SIZE (WORD_SIZE)
    ) u_next_pc_mux (
        .pc          (pc),
        .jalr_taken  (jalr_taken),
        .jalr_target (jalr_target),
        .jal_taken   (jal_taken),
        .jal_target  (jal_target),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .next_pc     (next_pc),
        .redirect    (redirect),
        .misaligned  (misaligned)
    );

    // pc_valid qualifies pc: the fetch stage may consume pc only in cycles where
    // pc_valid is 1; there is no back-pressure other than stall, which freezes pc.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_BOOT;
            pc           <= RESET_VECTOR;
            pc_valid     <= 1'b0;
            trap         <= 1'b0;
            trap_pc      <= '0;
            redirect_cnt <= '0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state    <= ST_RUN;
                    pc_valid <= 1'b1;
                end
                ST_RUN: begin
                    if (!stall) begin
                        if (misaligned) begin
                            trap     <= 1'b1;
                            trap_pc  <= next_pc;
                            pc_valid <= 1'b0;
                            state    <= ST_TRAP_WAIT;
                        end else begin
                            pc <= next_pc;
                            if (redirect && redirect_cnt != CNT_MAX) begin
                                redirect_cnt <= redirect_cnt + 16'd1;
                            end
                        end
                    end
                end
                ST_TRAP_WAIT: begin
                    // Stall is ignored here: the trap hand-off waits only for the control unit.
                    if (trap_ack) begin
                        pc       <= TRAP_VECTOR;
                        trap     <= 1'b0;
                        pc_valid <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                default: begin
                    state    <= ST_BOOT;
                    pc_valid <= 1'b0;
                    trap     <= 1'b0;
                end
            endcase
        end
    end

    assign link_addr = pc + PC_STEP;
    assign dbg_state = pcseq_state_t'(state);

endmodule
